term_char_writer: RTL

Parametrised character-stream-to-text-buffer writer for the VGA text terminal. Consumes bytes from a valid/ready source such as the UART receive path and tracks a cursor over a COLS×ROWS grid. Interprets CR, LF, BS, TAB and FF, and emits single-port write strobes into the text-mode character RAM. Optionally scrolls by rotating a top-row offset that the VGA text-mode reader adds to its row index, instead of copying RAM.

---
 rtl/term_char_writer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/term_char_writer.sv
// Byte-stream to text-mode character RAM writer with cursor tracking and control-code handling.
// Define TERM_SCROLL_EN to scroll by rotating top_row; otherwise the cursor wraps to row 0.
module term_char_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned TAB_W  = 8,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic                    clk100,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data,
    output logic [$clog2(ROWS)-1:0] top_row,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    busy
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    localparam logic [RW-1:0]     LastRow    = RW'(ROWS - 1);
    localparam logic [CW-1:0]     LastCol    = CW'(COLS - 1);
    localparam logic [ADDR_W-1:0] LineLast   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ScreenLast = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {StClrScreen, StIdle, StPut, StClrLine} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d, top_q, top_d;
    logic [CW-1:0]     col_q, col_d;
    logic              pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              in_ready_q, busy_q;

    logic              at_bottom;
    logic [RW-1:0]     adv_row, adv_top;
    logic [CW:0]       tab_sum;
    logic [CW-1:0]     tab_col;

    // Row base is computed at full address width so the modulo and multiply never truncate.
    function automatic logic [ADDR_W-1:0] phys(input logic [RW-1:0] row,
                                               input logic [RW-1:0] top,
                                               input logic [CW-1:0] col);
        logic [ADDR_W-1:0] sum;
        sum = ADDR_W'(row) + ADDR_W'(top);
        if (sum >= ADDR_W'(ROWS)) sum = sum - ADDR_W'(ROWS);
        return sum * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign at_bottom = (row_q == LastRow);
`ifdef TERM_SCROLL_EN
    assign adv_row = at_bottom ? LastRow : row_q + 1'b1;
    assign adv_top = !at_bottom ? top_q : ((top_q == LastRow) ? '0 : top_q + 1'b1);
`else
    assign adv_row = at_bottom ? '0 : row_q + 1'b1;
    assign adv_top = '0;
`endif

    assign tab_sum = {1'b0, col_q | CW'(TAB_W - 1)} + (CW + 1)'(1);
    assign tab_col = (tab_sum >= (CW + 1)'(COLS - 1)) ? LastCol : tab_sum[CW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        top_d     = top_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = FILL;

        unique case (state_q)
            StClrScreen: begin
                // wr_en_q low means the clear has not issued its first write yet (reset entry).
                if (!wr_en_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    cnt_d     = '0;
                end else if (cnt_q == ScreenLast) begin
                    state_d = StIdle;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (in_valid) begin
                    case (in_data)
                        8'h0A: begin
                            row_d = adv_row;
                            top_d = adv_top;
                            if (at_bottom) begin
                                state_d   = StClrLine;
                                cnt_d     = '0;
                                wr_en_d   = 1'b1;
                                wr_addr_d = phys(adv_row, adv_top, '0);
                            end
                        end
                        8'h0D: col_d = '0;
                        8'h08: if (col_q != '0) col_d = col_q - 1'b1;
                        8'h09: col_d = tab_col;
                        8'h0C: begin
                            top_d     = '0;
                            row_d     = '0;
                            col_d     = '0;
                            state_d   = StClrScreen;
                            cnt_d     = '0;
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                        end
                        default: begin
                            if (in_data >= 8'h20 && in_data != 8'h7F) begin
                                state_d   = StPut;
                                wr_en_d   = 1'b1;
                                wr_addr_d = phys(row_q, top_q, col_q);
                                wr_data_d = in_data;
                                pend_d    = 1'b0;
                                if (col_q == LastCol) begin
                                    col_d  = '0;
                                    row_d  = adv_row;
                                    top_d  = adv_top;
                                    pend_d = at_bottom;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            StPut: begin
                // Cursor registers already hold the post-advance position here.
                if (pend_q) begin
                    state_d   = StClrLine;
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = phys(row_q, top_q, '0);
                end else begin
                    state_d = StIdle;
                end
            end
            StClrLine: begin
                if (cnt_q == LineLast) begin
                    state_d = StIdle;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: state_d = StClrScreen;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q    <= StClrScreen;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            top_q      <= '0;
            pend_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= FILL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            top_q      <= top_d;
            pend_q     <= pend_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= (state_d == StIdle);
            busy_q     <= (state_d == StClrScreen) || (state_d == StClrLine);
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign top_row  = top_q;
    assign cur_row  = row_q;
    assign cur_col  = col_q;
    assign busy     = busy_q;

endmodule
